// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0004;
  localparam logic [31:0] WORD_BYTES        = 32'd4;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with deferred redirect, forced word alignment and sticky
// misalignment flag.
module fetch_pc_reg import fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_load_i,
  input  logic [31:0] pc_load_val_i,
  input  logic        busy_i,
  input  logic        advance_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_next_o,
  output logic        misalign_err_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic        pending_q, pending_d;
  logic        misalign_q, misalign_d;
  logic [31:0] aligned;

  assign aligned = {pc_load_val_i[31:2], 2'b00};

  always_comb begin
    pc_d       = pc_q;
    target_d   = target_q;
    pending_d  = pending_q;
    misalign_d = misalign_q | (pc_load_i & (pc_load_val_i[1:0] != 2'b00));
    if (advance_i) begin
      // A load arriving in the same cycle is the newest and overrides the pending one.
      pending_d = 1'b0;
      if (pc_load_i)      pc_d = aligned;
      else if (pending_q) pc_d = target_q;
      else                pc_d = pc_q + WORD_BYTES;
    end else if (pc_load_i) begin
      if (busy_i) begin
        pending_d = 1'b1;
        target_d  = aligned;
      end else begin
        pc_d = aligned;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      target_q   <= '0;
      pending_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      target_q   <= target_d;
      pending_q  <= pending_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_o           = pc_q;
  assign pc_next_o      = pc_d;
  assign misalign_err_o = misalign_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle fetch front end: issues one ROM read per request and delivers
// the registered instruction with a single-cycle valid pulse.
module instr_fetch_unit import fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned ROM_WORDS = 256,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req_i,
  input  logic        pc_load_i,
  input  logic [31:0] pc_load_val_i,
  output logic        hsel_o,
  output logic        rd_en_rom_o,
  output logic [31:0] address_rom_o,
  input  logic [31:0] instruction_i,
  output logic [31:0] ir_o,
  output logic [31:0] ir_pc_o,
  output logic        instr_valid_o,
  output logic [31:0] pc_o,
  output logic        busy_o,
  output logic        misalign_err_o,
  output logic        range_err_o
);

  localparam logic [31:0] RomBytes = 32'(ROM_WORDS) * WORD_BYTES;

  fetch_state_e state_q;
  logic         hsel_q, rd_en_q, oor_q, valid_q, range_err_q;
  logic [31:0]  addr_q, ir_q, ir_pc_q;
  logic [31:0]  pc, pc_next;
  logic         in_range;

  fetch_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .reset         (reset),
    .pc_load_i     (pc_load_i),
    .pc_load_val_i (pc_load_val_i),
    .busy_i        (state_q != StIdle),
    .advance_i     (state_q == StResp),
    .pc_o          (pc),
    .pc_next_o     (pc_next),
    .misalign_err_o(misalign_err_o)
  );

  // Range check uses the post-load PC so a same-cycle redirect fetches the new target.
  assign in_range = pc_next < RomBytes;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      hsel_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      oor_q       <= 1'b0;
      ir_q        <= '0;
      ir_pc_q     <= '0;
      valid_q     <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      valid_q     <= 1'b0;
      range_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (fetch_req_i) begin
            state_q <= StIssue;
            hsel_q  <= in_range;
            rd_en_q <= in_range;
            addr_q  <= in_range ? pc_next : '0;
            oor_q   <= ~in_range;
          end
        end
        StIssue: begin
          state_q <= StResp;
          hsel_q  <= 1'b0;
          rd_en_q <= 1'b0;
          addr_q  <= '0;
        end
        StResp: begin
          state_q     <= StIdle;
          ir_q        <= oor_q ? NOP_INSTR : instruction_i;
          ir_pc_q     <= pc;
          valid_q     <= 1'b1;
          range_err_q <= oor_q;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign hsel_o        = hsel_q;
  assign rd_en_rom_o   = rd_en_q;
  assign address_rom_o = addr_q;
  assign ir_o          = ir_q;
  assign ir_pc_o       = ir_pc_q;
  assign instr_valid_o = valid_q;
  assign range_err_o   = range_err_q;
  assign pc_o          = pc;
  assign busy_o        = state_q != StIdle;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a one-cycle registered ROM model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_req = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_load_val = '0;
  logic        hsel, rd_en_rom;
  logic [31:0] address_rom;
  logic [31:0] instruction = '0;
  logic [31:0] ir, ir_pc, pc;
  logic        instr_valid, busy, misalign_err, range_err;

  logic [31:0] mem [256];
  int          n_checks = 0;
  int          n_fails  = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_req_i   (fetch_req),
    .pc_load_i     (pc_load),
    .pc_load_val_i (pc_load_val),
    .hsel_o        (hsel),
    .rd_en_rom_o   (rd_en_rom),
    .address_rom_o (address_rom),
    .instruction_i (instruction),
    .ir_o          (ir),
    .ir_pc_o       (ir_pc),
    .instr_valid_o (instr_valid),
    .pc_o          (pc),
    .busy_o        (busy),
    .misalign_err_o(misalign_err),
    .range_err_o   (range_err)
  );

  always @(posedge clk) begin
    if (hsel && rd_en_rom) instruction <= mem[address_rom[9:2]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Pulse fetch_req in IDLE and check the full three-cycle transaction.
  task automatic run_fetch(input string tag, input logic [31:0] exp_addr,
                           input logic [31:0] exp_ir, input logic [31:0] exp_ir_pc,
                           input logic [31:0] exp_pc, input logic exp_oor);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    check_eq({tag, ".hsel"}, 32'(hsel), 32'(!exp_oor));
    check_eq({tag, ".rd_en"}, 32'(rd_en_rom), 32'(!exp_oor));
    check_eq({tag, ".addr"}, address_rom, exp_addr);
    tick();
    tick();
    check_eq({tag, ".valid"}, 32'(instr_valid), 32'd1);
    check_eq({tag, ".ir"}, ir, exp_ir);
    check_eq({tag, ".ir_pc"}, ir_pc, exp_ir_pc);
    check_eq({tag, ".pc"}, pc, exp_pc);
    check_eq({tag, ".range_err"}, 32'(range_err), 32'(exp_oor));
    tick();
    check_eq({tag, ".valid_drop"}, 32'(instr_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] seq_ir [4];
    seq_ir[0] = 32'h0020_8113;
    seq_ir[1] = 32'h0030_8193;
    seq_ir[2] = 32'h0040_A203;
    seq_ir[3] = 32'h0020_B423;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) mem[i + 1] = seq_ir[i];
    mem[6] = 32'h0040_8093;
    mem[7] = 32'h0013_8393;

    // Reset values and a single fetch
    do_reset();
    check_eq("rst.pc", pc, 32'h4);
    check_eq("rst.ir", ir, 32'h0);
    check_eq("rst.ir_pc", ir_pc, 32'h0);
    check_eq("rst.valid", 32'(instr_valid), 32'd0);
    check_eq("rst.hsel", 32'(hsel), 32'd0);
    check_eq("rst.addr", address_rom, 32'h0);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.misalign", 32'(misalign_err), 32'd0);
    check_eq("rst.range", 32'(range_err), 32'd0);
    run_fetch("single", 32'h4, 32'h0020_8113, 32'h4, 32'h8, 1'b0);

    // Back-to-back fetches with fetch_req held high
    do_reset();
    fetch_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        check_eq("b2b.valid", 32'(instr_valid), 32'(c == 2));
        check_eq("b2b.busy", 32'(busy), 32'(c != 2));
      end
      check_eq("b2b.ir", ir, seq_ir[k]);
      check_eq("b2b.ir_pc", ir_pc, 32'h4 + 32'(k) * 32'h4);
    end
    fetch_req = 1'b0;
    check_eq("b2b.pc", pc, 32'h14);

    // Redirect during RESP: in-flight instruction still delivered
    do_reset();
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    pc_load = 1'b1;
    pc_load_val = 32'h18;
    tick();
    pc_load = 1'b0;
    check_eq("redir_resp.valid", 32'(instr_valid), 32'd1);
    check_eq("redir_resp.ir", ir, 32'h0020_8113);
    check_eq("redir_resp.pc", pc, 32'h18);
    run_fetch("redir_next", 32'h18, 32'h0040_8093, 32'h18, 32'h1C, 1'b0);

    // Redirect during ISSUE is held pending until RESP
    do_reset();
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    pc_load = 1'b1;
    pc_load_val = 32'h1C;
    tick();
    pc_load = 1'b0;
    check_eq("pend.pc_hold", pc, 32'h4);
    tick();
    check_eq("pend.ir", ir, 32'h0020_8113);
    check_eq("pend.pc", pc, 32'h1C);

    // Load and fetch in the same IDLE cycle
    do_reset();
    pc_load = 1'b1;
    pc_load_val = 32'h1C;
    fetch_req = 1'b1;
    tick();
    pc_load = 1'b0;
    fetch_req = 1'b0;
    check_eq("same.addr", address_rom, 32'h1C);
    tick();
    tick();
    check_eq("same.ir", ir, 32'h0013_8393);
    check_eq("same.ir_pc", ir_pc, 32'h1C);

    // Misaligned load forces alignment and sets sticky flag
    do_reset();
    pc_load = 1'b1;
    pc_load_val = 32'h6;
    tick();
    pc_load = 1'b0;
    check_eq("mis.flag", 32'(misalign_err), 32'd1);
    check_eq("mis.pc", pc, 32'h4);
    run_fetch("mis_fetch", 32'h4, 32'h0020_8113, 32'h4, 32'h8, 1'b0);
    check_eq("mis.sticky", 32'(misalign_err), 32'd1);

    // Out-of-range fetch
    pc_load = 1'b1;
    pc_load_val = 32'h400;
    tick();
    pc_load = 1'b0;
    run_fetch("oor", 32'h0, 32'h0000_0013, 32'h400, 32'h404, 1'b1);
    check_eq("oor.range_drop", 32'(range_err), 32'd0);

    // PC wraps at the top of the address space
    pc_load = 1'b1;
    pc_load_val = 32'hFFFF_FFFC;
    tick();
    pc_load = 1'b0;
    run_fetch("wrap", 32'h0, 32'h0000_0013, 32'hFFFF_FFFC, 32'h0, 1'b1);

    // Reset during ISSUE aborts the fetch
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    check_eq("abort.busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    tick();
    check_eq("abort.pc", pc, 32'h4);
    check_eq("abort.ir", ir, 32'h0);
    check_eq("abort.valid", 32'(instr_valid), 32'd0);
    check_eq("abort.busy", 32'(busy), 32'd0);
    check_eq("abort.misalign", 32'(misalign_err), 32'd0);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("abort.no_valid", 32'(instr_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
